// File: rtl/pass_arbiter.sv
// Round-robin grant arbiter with burst cap, merging the granted requester's valid/data stream
// onto one registered output bus and flagging data offered by non-granted requesters.
module pass_arbiter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned N         = 3,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic [N-1:0]         i_Req,
    input  logic [N-1:0]         i_Valid,
    input  logic [N*WIDTH-1:0]   i_Data,
    output logic [N-1:0]         o_Grant,
    output logic                 o_Valid,
    output logic [WIDTH-1:0]     o_Data,
    output logic [$clog2(N)-1:0] o_Src,
    output logic                 o_Err
);

    localparam int unsigned SW = $clog2(N);
    localparam int unsigned BW = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0] BurstLast = BW'((MAX_BURST == 0) ? 0 : MAX_BURST - 1);

    typedef enum logic [0:0] {StIdle, StOwn} state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [SW-1:0]   ptr_q, ptr_d;
    logic [BW-1:0]   burst_q, burst_d;
    logic            valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SW-1:0]   src_q, src_d;
    logic            err_q, err_d;

    logic [SW-1:0]   owner;
    logic [SW-1:0]   pick;
    logic            hit;
    logic            keep_ok;

    always_comb begin
        owner = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_q[i]) owner = SW'(i);
        end
    end

    // Owner searches the N-1 others starting after itself; idle searches all N after the pointer.
    always_comb begin
        int unsigned base;
        int unsigned span;
        int unsigned idx;
        hit  = 1'b0;
        pick = owner;
        base = (state_q == StOwn) ? int'(owner) : int'(ptr_q);
        span = (state_q == StOwn) ? N - 1 : N;
        idx  = 0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = (base + i) % N;
            if (i <= span && !hit && i_Req[idx]) begin
                hit  = 1'b1;
                pick = SW'(idx);
            end
        end
    end

    assign keep_ok = (MAX_BURST == 0) || (burst_q < BurstLast);

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= SW'(N - 1);
            burst_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            src_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            burst_q <= burst_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            src_q   <= src_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        burst_d = burst_q;
        unique case (state_q)
            StIdle: begin
                if (hit) begin
                    state_d       = StOwn;
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    ptr_d         = pick;
                    burst_d       = '0;
                end
            end
            StOwn: begin
                if (i_Req[owner] && keep_ok) begin
                    if (MAX_BURST != 0) burst_d = burst_q + 1'b1;
                end else if (hit) begin
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    ptr_d         = pick;
                    burst_d       = '0;
                end else if (i_Req[owner]) begin
                    burst_d = '0;
                end else begin
                    state_d = StIdle;
                    grant_d = '0;
                    burst_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase

        // Merge path: only the current owner's data is captured; others are discarded.
        valid_d = 1'b0;
        data_d  = data_q;
        src_d   = src_q;
        if (state_q == StOwn && i_Valid[owner]) begin
            valid_d = 1'b1;
            data_d  = i_Data[owner*WIDTH +: WIDTH];
            src_d   = owner;
        end
        err_d = err_q | (|(i_Valid & ~grant_q));
    end

    always_comb begin
        o_Grant = grant_q;
        o_Valid = valid_q;
        o_Data  = data_q;
        o_Src   = src_q;
        o_Err   = err_q;
    end

endmodule
